// File: rtl/galaxian_pkg.sv
// Shared screen geometry, sprite defaults and the missile state type for the Galaxian datapath.
package galaxian_pkg;

  localparam int X_MAX         = 639;
  localparam int Y_MAX         = 479;
  localparam int MISSILE_W_DEF = 3;
  localparam int MISSILE_H_DEF = 6;

  typedef enum logic [1:0] {
    READY,
    FLY,
    COOL
  } missile_state_t;

  // Unsigned subtraction that stops at zero instead of wrapping.
  function automatic logic [9:0] sat_sub(input logic [9:0] a, input logic [9:0] b);
    return (a < b) ? 10'd0 : a - b;
  endfunction

endpackage

// File: rtl/hit_edge_encoder.sv
// Turns the aliens' sticky hit levels into rising-edge events and reports the lowest-index one.
module hit_edge_encoder #(
  parameter int N_ALIENS = 16,
  parameter int IDX_W    = (N_ALIENS > 1) ? $clog2(N_ALIENS) : 1
) (
  input  logic                frame_clk,
  input  logic                Reset,
  input  logic [N_ALIENS-1:0] alien_hit,
  output logic                hit_any,
  output logic [IDX_W-1:0]    hit_idx
);

  logic [N_ALIENS-1:0] hit_q;
  logic [N_ALIENS-1:0] hit_edge;

  // NOTE: reset loads the live flags rather than zero, so aliens already dead
  // when reset releases cannot produce a phantom rising edge afterwards.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) hit_q <= alien_hit;
    else       hit_q <= alien_hit;
  end

  assign hit_edge = alien_hit & ~hit_q;
  assign hit_any  = |hit_edge;

  // Scan downwards so the last assignment wins with the lowest set index.
  always_comb begin
    hit_idx = '0;
    for (int i = N_ALIENS - 1; i >= 0; i--) begin
      if (hit_edge[i]) hit_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/player_missile.sv
// Player missile: launch from the ship, climb once per frame, retire on a fresh alien hit
// or at the top of the screen, then hold off re-firing for a cooldown period.
module player_missile
  import galaxian_pkg::*;
#(
  parameter int  N_ALIENS  = 16,
  parameter int  MISSILE_W = MISSILE_W_DEF,
  parameter int  MISSILE_H = MISSILE_H_DEF,
  parameter int  SHIP_W    = 25,
  parameter int  STEP      = 4,
  parameter int  COOLDOWN  = 8,
  parameter int  PARK_Y    = 479,
  localparam int IDX_W     = (N_ALIENS > 1) ? $clog2(N_ALIENS) : 1
) (
  input  logic                Reset,
  input  logic                frame_clk,
  input  logic                fire,
  input  logic [9:0]          ShipX,
  input  logic [9:0]          ShipY,
  input  logic [N_ALIENS-1:0] alien_hit,
  output logic [9:0]          PlayerMissileX,
  output logic [9:0]          PlayerMissileY,
  output logic [9:0]          PlayerMissileS,
  output logic                missile_active,
  output logic                kill_pulse,
  output logic [IDX_W-1:0]    kill_index
);

  localparam int CNT_W  = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam int LX_OFF = SHIP_W / 2 - MISSILE_W / 2;
  localparam int X_LIM  = X_MAX - MISSILE_W + 1;

  localparam logic [9:0]       STEP_V    = 10'(STEP);
  localparam logic [9:0]       PARK_V    = 10'(PARK_Y);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN - 1);

  missile_state_t   state;
  logic             fire_q;
  logic             fire_edge;
  logic [CNT_W-1:0] cool_cnt;
  logic             hit_any;
  logic [IDX_W-1:0] hit_idx;
  logic [10:0]      lx_sum;
  logic [9:0]       launch_x;
  logic [9:0]       launch_y;

  hit_edge_encoder #(
    .N_ALIENS (N_ALIENS),
    .IDX_W    (IDX_W)
  ) u_hit_enc (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .alien_hit (alien_hit),
    .hit_any   (hit_any),
    .hit_idx   (hit_idx)
  );

  assign fire_edge = fire & ~fire_q;

  // Centre on the ship; keep the missile on-screen instead of letting X wrap.
  assign lx_sum   = {1'b0, ShipX} + 11'(LX_OFF);
  assign launch_x = (lx_sum > 11'(X_LIM)) ? 10'(X_LIM) : lx_sum[9:0];
  assign launch_y = sat_sub(ShipY, 10'(MISSILE_H));

  assign PlayerMissileS = 10'(MISSILE_W);

  // NOTE: every register here uses non-blocking assignment so all of them
  // see the pre-edge values of each other, whatever the statement order.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state          <= READY;
      fire_q         <= 1'b1;
      cool_cnt       <= '0;
      PlayerMissileX <= '0;
      PlayerMissileY <= PARK_V;
      missile_active <= 1'b0;
      kill_pulse     <= 1'b0;
      kill_index     <= '0;
    end else begin
      fire_q     <= fire;
      kill_pulse <= 1'b0;
      case (state)
        READY: begin
          if (fire_edge) begin
            state          <= FLY;
            PlayerMissileX <= launch_x;
            PlayerMissileY <= launch_y;
            missile_active <= 1'b1;
          end
        end
        FLY: begin
          // A hit outranks leaving the top in the same frame.
          if (hit_any || PlayerMissileY < STEP_V) begin
            state          <= COOL;
            cool_cnt       <= COOL_LOAD;
            PlayerMissileX <= '0;
            PlayerMissileY <= PARK_V;
            missile_active <= 1'b0;
            if (hit_any) begin
              kill_pulse <= 1'b1;
              kill_index <= hit_idx;
            end
          end else begin
            PlayerMissileY <= PlayerMissileY - STEP_V;
          end
        end
        COOL: begin
          if (cool_cnt == '0) state <= READY;
          else                cool_cnt <= cool_cnt - 1'b1;
        end
        default: begin
          state          <= READY;
          PlayerMissileX <= '0;
          PlayerMissileY <= PARK_V;
          missile_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_missile.sv
// Self-checking bench for player_missile: directed table, corner-case sequences, random run.
module tb_player_missile;

  localparam int PARK    = 479;
  localparam int CD      = 8;
  localparam int STEP_PX = 4;
  localparam int X_OFF   = 11;   // 25/2 - 3/2
  localparam int X_CLAMP = 637;  // 639 - 3 + 1

  logic        Reset;
  logic        frame_clk = 1'b0;
  logic        fire;
  logic [9:0]  ShipX;
  logic [9:0]  ShipY;
  logic [15:0] alien_hit;
  logic [9:0]  PlayerMissileX;
  logic [9:0]  PlayerMissileY;
  logic [9:0]  PlayerMissileS;
  logic        missile_active;
  logic        kill_pulse;
  logic [3:0]  kill_index;

  player_missile dut (
    .Reset          (Reset),
    .frame_clk      (frame_clk),
    .fire           (fire),
    .ShipX          (ShipX),
    .ShipY          (ShipY),
    .alien_hit      (alien_hit),
    .PlayerMissileX (PlayerMissileX),
    .PlayerMissileY (PlayerMissileY),
    .PlayerMissileS (PlayerMissileS),
    .missile_active (missile_active),
    .kill_pulse     (kill_pulse),
    .kill_index     (kill_index)
  );

  always #5 frame_clk = ~frame_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: where the missile is and how many frames of cooldown remain.
  bit          m_fly;
  int          m_x, m_y;
  int          m_cool_left;
  bit          m_prev_fire;
  logic [15:0] m_prev_hit;
  bit          m_pulse;
  int          m_idx;

  typedef struct {
    bit          fire;
    logic [15:0] hit;
    int          sx, sy;
    int          ex, ey;
    bit          ea, ep;
    int          ei;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_fly       = 1'b0;
    m_cool_left = 0;
    m_prev_fire = 1'b1;
    m_prev_hit  = alien_hit;
    m_pulse     = 1'b0;
    m_idx       = 0;
  endtask

  task automatic model_edge();
    logic [15:0] rise;
    bit          fe;
    rise    = alien_hit & ~m_prev_hit;
    fe      = fire && !m_prev_fire;
    m_pulse = 1'b0;
    if (m_fly) begin
      if (rise != 0) begin
        m_pulse = 1'b1;
        for (int i = 0; i < 16; i++) begin
          if (rise[i]) begin
            m_idx = i;
            break;
          end
        end
        m_fly       = 1'b0;
        m_cool_left = CD;
      end else if (m_y < STEP_PX) begin
        m_fly       = 1'b0;
        m_cool_left = CD;
      end else begin
        m_y = m_y - STEP_PX;
      end
    end else if (m_cool_left > 0) begin
      m_cool_left--;
    end else if (fe) begin
      m_fly = 1'b1;
      m_x   = int'(ShipX) + X_OFF;
      if (m_x > X_CLAMP) m_x = X_CLAMP;
      m_y = (int'(ShipY) < 6) ? 0 : int'(ShipY) - 6;
    end
    m_prev_fire = fire;
    m_prev_hit  = alien_hit;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".x"},      32'(PlayerMissileX), m_fly ? m_x : 0);
    check({tag, ".y"},      32'(PlayerMissileY), m_fly ? m_y : PARK);
    check({tag, ".active"}, 32'(missile_active), 32'(m_fly));
    check({tag, ".pulse"},  32'(kill_pulse),     32'(m_pulse));
    check({tag, ".idx"},    32'(kill_index),     m_idx);
    check({tag, ".size"},   32'(PlayerMissileS), 3);
  endtask

  task automatic step();
    @(posedge frame_clk);
    model_edge();
    #1;
    cyc++;
    compare_all($sformatf("cyc%0d", cyc));
  endtask

  task automatic steps(input int n, input bit f);
    fire = f;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #2;
    check("rst.x",      32'(PlayerMissileX), 0);
    check("rst.y",      32'(PlayerMissileY), PARK);
    check("rst.active", 32'(missile_active), 0);
    check("rst.pulse",  32'(kill_pulse),     0);
    check("rst.idx",    32'(kill_index),     0);
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_fly, n_pulse;

    Reset     = 1'b1;
    fire      = 1'b0;
    ShipX     = 10'd300;
    ShipY     = 10'd440;
    alien_hit = 16'h0000;
    do_reset();

    // Launch, two climbs, hit on alien 5 held high, fire edge during cooldown.
    tbl[0] = '{1'b0, 16'h0000, 300, 440,   0, 479, 1'b0, 1'b0, 0};
    tbl[1] = '{1'b1, 16'h0000, 300, 440, 311, 434, 1'b1, 1'b0, 0};
    tbl[2] = '{1'b1, 16'h0000, 300, 440, 311, 430, 1'b1, 1'b0, 0};
    tbl[3] = '{1'b0, 16'h0000, 300, 440, 311, 426, 1'b1, 1'b0, 0};
    tbl[4] = '{1'b0, 16'h0020, 300, 440,   0, 479, 1'b0, 1'b1, 5};
    tbl[5] = '{1'b0, 16'h0020, 300, 440,   0, 479, 1'b0, 1'b0, 5};
    tbl[6] = '{1'b1, 16'h0020, 300, 440,   0, 479, 1'b0, 1'b0, 5};
    for (int i = 0; i < 7; i++) begin
      fire      = tbl[i].fire;
      alien_hit = tbl[i].hit;
      ShipX     = 10'(tbl[i].sx);
      ShipY     = 10'(tbl[i].sy);
      step();
      check($sformatf("tbl%0d.x", i),      32'(PlayerMissileX), tbl[i].ex);
      check($sformatf("tbl%0d.y", i),      32'(PlayerMissileY), tbl[i].ey);
      check($sformatf("tbl%0d.active", i), 32'(missile_active), 32'(tbl[i].ea));
      check($sformatf("tbl%0d.pulse", i),  32'(kill_pulse),     32'(tbl[i].ep));
      check($sformatf("tbl%0d.idx", i),    32'(kill_index),     tbl[i].ei);
    end

    // Fire held through cooldown into READY must not relaunch.
    steps(12, 1'b1);
    check("held_fire.no_relaunch", 32'(missile_active), 0);
    steps(1, 1'b0);
    steps(1, 1'b1);
    check("repress.active", 32'(missile_active), 1);
    check("repress.x",      32'(PlayerMissileX), 311);
    check("repress.y",      32'(PlayerMissileY), 434);

    // Fly off the top: 434 down to 2 in steps of 4 is 109 frames, no kills.
    fire    = 1'b0;
    n_fly   = 1;
    n_pulse = 0;
    while (missile_active && n_fly < 300) begin
      step();
      if (missile_active) n_fly++;
      if (kill_pulse) n_pulse++;
    end
    check("offtop.frames", n_fly, 109);
    check("offtop.pulses", n_pulse, 0);

    // Press on the 8th cooldown edge is still ignored.
    steps(7, 1'b0);
    steps(1, 1'b1);
    check("cool8.ignored", 32'(missile_active), 0);
    steps(1, 1'b0);
    steps(1, 1'b1);
    check("after_cool.launch", 32'(missile_active), 1);

    // Two aliens rise together: one kill, lowest index.
    steps(3, 1'b0);
    alien_hit = 16'h0224;
    steps(1, 1'b0);
    check("multi.pulse",  32'(kill_pulse),     1);
    check("multi.idx",    32'(kill_index),     2);
    check("multi.y",      32'(PlayerMissileY), PARK);
    steps(1, 1'b0);
    check("multi.once",   32'(kill_pulse),     0);

    // Press on the edge right after cooldown expires launches; low ship gives Y=2.
    steps(7, 1'b0);
    ShipY = 10'd8;
    steps(1, 1'b1);
    check("cool_exact.active", 32'(missile_active), 1);
    check("cool_exact.y",      32'(PlayerMissileY), 2);

    // Hit coincides with Y < STEP: the hit still scores.
    alien_hit = 16'h1224;
    steps(1, 1'b0);
    check("hit_top.pulse", 32'(kill_pulse), 1);
    check("hit_top.idx",   32'(kill_index), 12);

    // Reset mid-flight with a stale hit flag already high.
    steps(9, 1'b0);
    ShipY = 10'd406;
    steps(1, 1'b1);
    steps(50, 1'b0);
    check("midfly.y", 32'(PlayerMissileY), 200);
    alien_hit = 16'h1225;
    do_reset();
    ShipY = 10'd3;
    steps(1, 1'b0);
    check("stale.pulse0", 32'(kill_pulse), 0);
    steps(1, 1'b1);
    check("shipy3.active", 32'(missile_active), 1);
    check("shipy3.y",      32'(PlayerMissileY), 0);
    steps(1, 1'b0);
    check("stale.pulse1", 32'(kill_pulse),     0);
    check("shipy3.retire", 32'(missile_active), 0);

    // Random traffic against the model.
    alien_hit = 16'h0000;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        alien_hit = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom);
        do_reset();
      end
      if ($urandom_range(0, 7) == 0) ShipX = 10'($urandom_range(0, 620));
      if ($urandom_range(0, 7) == 0) ShipY = 10'($urandom_range(0, 479));
      if ($urandom_range(0, 11) == 0) begin
        alien_hit = alien_hit | (16'h1 << $urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) alien_hit = alien_hit | (16'h1 << $urandom_range(0, 15));
      end
      if ($urandom_range(0, 499) == 0) alien_hit = 16'h0000;
      fire = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
